// File: rtl/riscv_pkg.sv
// Shared MMIO register map, ID constant and STATUS layout
// for the data-port peripheral responder.
package riscv_pkg;

    localparam logic [7:0] MmioTxDataOff     = 8'h00;
    localparam logic [7:0] MmioStatusOff     = 8'h04;
    localparam logic [7:0] MmioRxDataOff     = 8'h08;
    localparam logic [7:0] MmioMtimeLoOff    = 8'h0C;
    localparam logic [7:0] MmioMtimeHiOff    = 8'h10;
    localparam logic [7:0] MmioMtimecmpLoOff = 8'h14;
    localparam logic [7:0] MmioMtimecmpHiOff = 8'h18;
    localparam logic [7:0] MmioMsipOff       = 8'h1C;
    localparam logic [7:0] MmioScratchOff    = 8'h20;
    localparam logic [7:0] MmioIdOff         = 8'h24;

    localparam logic [31:0] MMIO_ID = 32'h4652_5354;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_count;
        logic [7:0] tx_count;
        logic [4:0] rsvd_lo;
        logic       tx_overflow;
        logic       rx_nonempty;
        logic       tx_full;
    } mmio_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; full/empty/count derive only from registered state.
// A pop frees a slot for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target: UART FIFOs, machine timer, msip, scratch and ID.
// Read data is registered one cycle after the strobe, like BRAM.
module mmio_responder
    import riscv_pkg::*;
#(
    parameter int               XLEN            = 32,
    parameter logic [XLEN-1:0]  MMIO_ADDR       = 32'h4000_0000,
    parameter logic [XLEN-1:0]  MMIO_SIZE_BYTES = 32'h28,
    parameter int               FIFO_DEPTH      = 16,
    parameter int               TIMER_DIV       = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_addr,
    input  logic            i_rd_en,
    input  logic [3:0]      i_wr_en,
    input  logic [XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0] o_rd_data,
    output logic [7:0]      o_uart_tx_data,
    output logic            o_uart_tx_valid,
    input  logic            i_uart_tx_ready,
    input  logic [7:0]      i_uart_rx_data,
    input  logic            i_uart_rx_valid,
    output logic            o_uart_rx_ready,
    output logic            o_timer_irq,
    output logic            o_soft_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    function automatic logic [XLEN-1:0] merge(
        input logic [XLEN-1:0] old,
        input logic [XLEN-1:0] data,
        input logic [3:0]      be
    );
        merge = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge[i*8 +: 8] = data[i*8 +: 8];
    endfunction

    logic [XLEN-1:0]   rel;
    logic [7:0]        off;
    logic              hit;
    logic              wr;
    logic              rd;
    logic [XLEN-1:0]   rd_val;

    logic [2*XLEN-1:0] mtime;
    logic [2*XLEN-1:0] mtimecmp;
    logic [PW-1:0]     presc;
    logic              tick;
    logic              msip;
    logic [XLEN-1:0]   scratch;
    logic              tx_overflow;
    mmio_status_t      status;

    logic              tx_push;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;
    logic [7:0]        rx_head;

    assign rel = i_addr - MMIO_ADDR;
    assign hit = (rel < MMIO_SIZE_BYTES);
    assign off = {rel[7:2], 2'b00};
    assign wr  = hit && (i_wr_en != 4'b0);
    assign rd  = hit && i_rd_en;

    assign tx_push = wr && (off == MmioTxDataOff) && i_wr_en[0];
    assign rx_pop  = rd && (off == MmioRxDataOff);
    assign tick    = (presc == PW'(TIMER_DIV - 1));

    assign o_uart_tx_valid = !tx_empty;
    assign o_uart_rx_ready = !rx_full;
    assign o_soft_irq      = msip;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (tx_push),
        .push_data (i_wr_data[7:0]),
        .pop       (i_uart_tx_ready),
        .pop_data  (o_uart_tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (i_uart_rx_valid),
        .push_data (i_uart_rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        status             = '0;
        status.tx_full     = tx_full;
        status.rx_nonempty = !rx_empty;
        status.tx_overflow = tx_overflow;
        status.tx_count    = 8'(tx_count);
        status.rx_count    = 8'(rx_count);
    end

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (off)
                MmioStatusOff:     rd_val = XLEN'(status);
                MmioRxDataOff:     rd_val = XLEN'({!rx_empty, rx_head});
                MmioMtimeLoOff:    rd_val = mtime[XLEN-1:0];
                MmioMtimeHiOff:    rd_val = mtime[2*XLEN-1:XLEN];
                MmioMtimecmpLoOff: rd_val = mtimecmp[XLEN-1:0];
                MmioMtimecmpHiOff: rd_val = mtimecmp[2*XLEN-1:XLEN];
                MmioMsipOff:       rd_val = XLEN'(msip);
                MmioScratchOff:    rd_val = scratch;
                MmioIdOff:         rd_val = XLEN'(MMIO_ID);
                default:           rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_data   <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            presc       <= '0;
            msip        <= 1'b0;
            scratch     <= '0;
            tx_overflow <= 1'b0;
            o_timer_irq <= 1'b0;
        end else begin
            if (i_rd_en) o_rd_data <= rd_val;

            presc <= tick ? '0 : presc + 1'b1;

            // a CPU write to either half freezes the whole counter this cycle
            if (wr && off == MmioMtimeLoOff)
                mtime[XLEN-1:0] <= merge(mtime[XLEN-1:0], i_wr_data, i_wr_en);
            else if (wr && off == MmioMtimeHiOff)
                mtime[2*XLEN-1:XLEN] <=
                    merge(mtime[2*XLEN-1:XLEN], i_wr_data, i_wr_en);
            else if (tick)
                mtime <= mtime + 1'b1;

            if (wr && off == MmioMtimecmpLoOff)
                mtimecmp[XLEN-1:0] <=
                    merge(mtimecmp[XLEN-1:0], i_wr_data, i_wr_en);
            if (wr && off == MmioMtimecmpHiOff)
                mtimecmp[2*XLEN-1:XLEN] <=
                    merge(mtimecmp[2*XLEN-1:XLEN], i_wr_data, i_wr_en);

            if (wr && off == MmioMsipOff && i_wr_en[0])
                msip <= i_wr_data[0];
            if (wr && off == MmioScratchOff)
                scratch <= merge(scratch, i_wr_data, i_wr_en);

            if (wr && off == MmioStatusOff)
                tx_overflow <= 1'b0;
            else if (tx_push && tx_full && !i_uart_tx_ready)
                tx_overflow <= 1'b1;

            o_timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: reads go through an expected-value
// queue checked by a monitor; side-band outputs are checked inline.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd_en;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        timer_irq;
    logic        soft_irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic pend  = 1'b0;

    localparam logic [31:0] B = 32'h4000_0000;

    always #5 clk = ~clk;

    mmio_responder dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_addr          (addr),
        .i_rd_en         (rd_en),
        .i_wr_en         (wr_en),
        .i_wr_data       (wr_data),
        .o_rd_data       (rd_data),
        .o_uart_tx_data  (tx_data),
        .o_uart_tx_valid (tx_valid),
        .i_uart_tx_ready (tx_ready),
        .i_uart_rx_data  (rx_data),
        .i_uart_rx_valid (rx_valid),
        .o_uart_rx_ready (rx_ready),
        .o_timer_irq     (timer_irq),
        .o_soft_irq      (soft_irq)
    );

    always @(posedge clk) pend <= rd_en && !rst;

    always @(negedge clk) begin
        if (pend) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_read: got %h expected none", rd_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rd_data !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", e.name, rd_data, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wr_data = d; wr_en = be;
        step();
        wr_en = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name; e.exp = exp;
        sb.push_back(e);
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; rd_en = 0; wr_en = 0; wr_data = '0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        step(); step();
        rst = 1'b0;

        chk("rst_rd_data", rd_data, 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_rx_ready", 32'(rx_ready), 1);
        chk("rst_timer_irq", 32'(timer_irq), 0);
        chk("rst_soft_irq", 32'(soft_irq), 0);

        rd(B + 32'h24, 32'h4652_5354, "id");
        rd(B + 32'h00, 32'h0, "tx_data_rd");
        rd(B + 32'h28, 32'h0, "miss_rd");

        wr(B, 32'h41, 4'h1);
        wr(B, 32'h42, 4'h1);
        rd(B + 32'h04, 32'h0000_0200, "status_tx2");
        chk("tx_head_41", 32'(tx_data), 32'h41);
        chk("tx_valid_2", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        step();
        chk("tx_head_42", 32'(tx_data), 32'h42);
        step();
        chk("tx_drained", 32'(tx_valid), 0);
        tx_ready = 1'b0;

        for (int i = 0; i < 17; i++) wr(B, 32'h60 + i, 4'h1);
        rd(B + 32'h04, 32'h0000_1005, "status_full_ovf");
        wr(B + 32'h04, 32'h0, 4'hF);
        rd(B + 32'h04, 32'h0000_1001, "status_ovf_clr");
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_order_%0d", i), 32'(tx_data), 32'h60 + i);
            step();
        end
        tx_ready = 1'b0;
        chk("tx_empty_after16", 32'(tx_valid), 0);

        rx_push(8'h5A);
        rd(B + 32'h04, 32'h0001_0002, "status_rx1");
        rd(B + 32'h08, 32'h0000_015A, "rx_pop_5a");
        rd(B + 32'h08, 32'h0, "rx_empty_rd");
        rd(B + 32'h04, 32'h0, "status_rx0");

        rx_push(8'h33);
        begin
            exp_t e;
            e.name = "rx_pop_push"; e.exp = 32'h133;
            sb.push_back(e);
            addr = B + 32'h08; rd_en = 1; rx_data = 8'h44; rx_valid = 1;
            step();
            rd_en = 0; rx_valid = 0;
        end
        rd(B + 32'h04, 32'h0001_0002, "status_rx_keep1");
        rd(B + 32'h08, 32'h0000_0144, "rx_pop_44");

        for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
        chk("rx_ready_full", 32'(rx_ready), 0);
        rx_push(8'hFF);
        rd(B + 32'h04, 32'h0010_0002, "status_rx16");
        for (int i = 0; i < 16; i++)
            rd(B + 32'h08, 32'h180 + i, $sformatf("rx_order_%0d", i));
        rd(B + 32'h04, 32'h0, "status_rx_drained");

        wr(B + 32'h18, 32'h0, 4'hF);
        wr(B + 32'h14, 32'd10, 4'hF);
        wr(B + 32'h10, 32'h0, 4'hF);
        wr(B + 32'h0C, 32'h0, 4'hF);
        repeat (10) step();
        chk("irq_before_10", 32'(timer_irq), 0);
        step();
        chk("irq_at_10", 32'(timer_irq), 1);

        wr(B + 32'h10, 32'h0, 4'hF);
        wr(B + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        rd(B + 32'h0C, 32'hFFFF_FFFF, "mtime_lo_max");
        rd(B + 32'h10, 32'h1, "mtime_hi_carry");
        rd(B + 32'h0C, 32'h1, "mtime_lo_after");

        begin
            exp_t e;
            e.name = "scratch_rd_wr_same"; e.exp = 32'h0;
            sb.push_back(e);
            addr = B + 32'h20; rd_en = 1; wr_en = 4'hF; wr_data = 32'hDEAD_BEEF;
            step();
            rd_en = 0; wr_en = 0;
        end
        rd(B + 32'h20, 32'hDEAD_BEEF, "scratch_full");
        wr(B + 32'h20, 32'h1122_3344, 4'b0011);
        rd(B + 32'h20, 32'hDEAD_3344, "scratch_be");

        wr(B + 32'h1C, 32'h3, 4'hF);
        chk("soft_irq_set", 32'(soft_irq), 1);
        rd(B + 32'h1C, 32'h1, "msip_rd");
        wr(B + 32'h24, 32'h0, 4'hF);
        rd(B + 32'h24, 32'h4652_5354, "id_ro");

        wr(B, 32'h11, 4'h1);
        wr(B, 32'h22, 4'h1);
        chk("pre_rst_tx_valid", 32'(tx_valid), 1);
        rst = 1'b1; addr = B + 32'h24; rd_en = 1'b1;
        step();
        rst = 1'b0; rd_en = 1'b0;
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 1);
        chk("mid_rst_timer_irq", 32'(timer_irq), 0);
        chk("mid_rst_soft_irq", 32'(soft_irq), 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
